// File: rtl/sdram_burst_arbiter_pkg.sv
// Shared constants, FSM encoding and port IDs for the SDRAM burst arbiter slice.
package sdram_pkg;

  localparam int BURST_LEN_DEF    = 512;
  localparam int FRAME_BURSTS_DEF = 600;
  localparam int RD_LOW_MARK_DEF  = 250;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 10;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_GRANT     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  // Cycles WAIT_BUSY tolerates ctrl_ready staying high before giving up (count 0..3)
  localparam logic [1:0] WB_LAST = 2'd3;

  typedef enum logic [1:0] {
    PORT_SOB = 2'd0,
    PORT_CAM = 2'd1,
    PORT_VGA = 2'd2
  } port_e;

  function automatic logic [31:0] cnt_ext(input logic [CNT_W-1:0] c);
    return {{(32-CNT_W){1'b0}}, c};
  endfunction

endpackage

// File: rtl/sdram_burst_arbiter_if.sv
// Arbiter <-> SDRAM controller command/data bundle; master = arbiter, slave = controller.
interface sdram_burst_arbiter_if;
  import sdram_pkg::*;

  logic              ctrl_ready;
  logic              ctrl_wr_valid;
  logic              ctrl_rw;
  logic              ctrl_rw_en;
  logic [ADDR_W-1:0] ctrl_addr;
  logic [DATA_W-1:0] ctrl_wdata;

  modport master (
    input  ctrl_ready,
    input  ctrl_wr_valid,
    output ctrl_rw,
    output ctrl_rw_en,
    output ctrl_addr,
    output ctrl_wdata
  );

  modport slave (
    output ctrl_ready,
    output ctrl_wr_valid,
    input  ctrl_rw,
    input  ctrl_rw_en,
    input  ctrl_addr,
    input  ctrl_wdata
  );

endinterface

// File: rtl/sdram_burst_arbiter_burst_ptr.sv
// Wrapping burst pointer 0..NUM-1 presented as BASE+ptr; advances by one per i_adv.
// o_wrap is combinational: high during the advance that returns the pointer to 0.
module burst_ptr
  import sdram_pkg::*;
#(
  parameter int NUM  = FRAME_BURSTS_DEF,
  parameter int BASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_adv,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_wrap
);

  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(NUM - 1);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

  logic [ADDR_W-1:0] r_ptr;

  assign o_wrap = i_adv && (r_ptr == LAST);
  assign o_addr = r_ptr + BASE_A;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= o_wrap ? '0 : r_ptr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Grants full-page SDRAM bursts: VGA read (strict priority), Sobel write, camera write with ORIG_PORT_EN.
// One burst in flight; grant = one-cycle ctrl_rw_en, next arbitration waits for ctrl_ready to return.
module sdram_burst_arbiter
  import sdram_pkg::*;
#(
  parameter int BURST_LEN    = BURST_LEN_DEF,
  parameter int FRAME_BURSTS = FRAME_BURSTS_DEF,
  parameter int RD_LOW_MARK  = RD_LOW_MARK_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CNT_W-1:0]      sob_count,
  input  logic [DATA_W-1:0]     sob_data,
  output logic                  sob_rd,
`ifdef ORIG_PORT_EN
  input  logic [CNT_W-1:0]      cam_count,
  input  logic [DATA_W-1:0]     cam_data,
  output logic                  cam_rd,
`endif
  input  logic [CNT_W-1:0]      vga_count,
  input  logic                  vga_sel_orig,
  sdram_burst_arbiter_if.master ctrl,
  output logic                  busy,
  output logic                  frame_done
);

  localparam logic [31:0]       BURST_U  = BURST_LEN;
  localparam logic [31:0]       RD_MARK  = RD_LOW_MARK;
  localparam logic [ADDR_W-1:0] CAM_BASE = ADDR_W'(FRAME_BURSTS);

  logic [1:0]        r_state;
  logic [1:0]        r_wb_cnt;
  port_e             r_port;
  port_e             r_last;
  logic              r_sel;
  logic              r_frame_done;

  logic              w_busy;
  logic              w_grant;
  logic              w_rd_req;
  logic              w_sob_req;
  logic              w_cam_req;
  logic              w_req_vld;
  port_e             w_req_port;
  logic              w_sel_src;
  logic [ADDR_W-1:0] w_sob_addr;
  logic [ADDR_W-1:0] w_cam_addr;
  logic [ADDR_W-1:0] w_rd_ptr_addr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_cam_data;
  logic              w_sob_wrap;
  logic              w_rd_wrap;

  assign w_busy    = (r_state != ST_IDLE);
  assign w_grant   = (r_state == ST_GRANT);
  assign w_rd_req  = cnt_ext(vga_count) < RD_MARK;
  assign w_sob_req = cnt_ext(sob_count) >= BURST_U;

`ifdef ORIG_PORT_EN
  logic w_unused_cam_wrap;

  assign w_cam_req  = cnt_ext(cam_count) >= BURST_U;
  assign w_sel_src  = vga_sel_orig;
  assign w_cam_data = cam_data;
  assign cam_rd     = ctrl.ctrl_wr_valid && w_busy && (r_port == PORT_CAM);

  burst_ptr #(
    .NUM  (FRAME_BURSTS),
    .BASE (FRAME_BURSTS)
  ) u_cam_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_adv  (w_grant && (r_port == PORT_CAM)),
    .o_addr (w_cam_addr),
    .o_wrap (w_unused_cam_wrap)
  );
`else
  logic w_unused_sel;

  assign w_cam_req    = 1'b0;
  assign w_sel_src    = 1'b0;
  assign w_cam_data   = '0;
  assign w_cam_addr   = '0;
  assign w_unused_sel = vga_sel_orig;
`endif

  burst_ptr #(
    .NUM  (FRAME_BURSTS),
    .BASE (0)
  ) u_sob_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_adv  (w_grant && (r_port == PORT_SOB)),
    .o_addr (w_sob_addr),
    .o_wrap (w_sob_wrap)
  );

  burst_ptr #(
    .NUM  (FRAME_BURSTS),
    .BASE (0)
  ) u_rd_ptr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_adv  (w_grant && (r_port == PORT_VGA)),
    .o_addr (w_rd_ptr_addr),
    .o_wrap (w_rd_wrap)
  );

  // Display region chosen per frame so a frame never mixes Sobel and camera lines
  assign w_rd_addr = w_rd_ptr_addr + (r_sel ? CAM_BASE : ADDR_W'(0));

  // Read wins outright; between writes the port granted last yields on a tie
  always_comb begin
    w_req_vld  = 1'b0;
    w_req_port = PORT_SOB;
    if (w_rd_req) begin
      w_req_vld  = 1'b1;
      w_req_port = PORT_VGA;
    end else if (w_sob_req && w_cam_req) begin
      w_req_vld  = 1'b1;
      w_req_port = (r_last == PORT_CAM) ? PORT_SOB : PORT_CAM;
    end else if (w_sob_req) begin
      w_req_vld  = 1'b1;
      w_req_port = PORT_SOB;
    end else if (w_cam_req) begin
      w_req_vld  = 1'b1;
      w_req_port = PORT_CAM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_wb_cnt <= '0;
      r_port   <= PORT_SOB;
      r_last   <= PORT_CAM;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ctrl.ctrl_ready && w_req_vld) begin
            r_state <= ST_GRANT;
            r_port  <= w_req_port;
            if (w_req_port != PORT_VGA) begin
              r_last <= w_req_port;
            end
          end
        end
        ST_GRANT: begin
          r_state  <= ST_WAIT_BUSY;
          r_wb_cnt <= '0;
        end
        ST_WAIT_BUSY: begin
          // Controller that never drops ready must not lock the arbiter
          if (!ctrl.ctrl_ready) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_wb_cnt == WB_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_wb_cnt <= r_wb_cnt + 2'd1;
          end
        end
        ST_WAIT_DONE: begin
          if (ctrl.ctrl_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_sob_wrap;
      if (w_rd_wrap) begin
        r_sel <= w_sel_src;
      end
    end
  end

  always_comb begin
    ctrl.ctrl_rw_en = 1'b0;
    ctrl.ctrl_rw    = 1'b0;
    ctrl.ctrl_addr  = '0;
    if (w_grant) begin
      ctrl.ctrl_rw_en = 1'b1;
      ctrl.ctrl_rw    = (r_port == PORT_VGA);
      case (r_port)
        PORT_SOB: ctrl.ctrl_addr = w_sob_addr;
        PORT_CAM: ctrl.ctrl_addr = w_cam_addr;
        default:  ctrl.ctrl_addr = w_rd_addr;
      endcase
    end
  end

  always_comb begin
    ctrl.ctrl_wdata = '0;
    if (w_busy && (r_port == PORT_SOB)) begin
      ctrl.ctrl_wdata = sob_data;
    end else if (w_busy && (r_port == PORT_CAM)) begin
      ctrl.ctrl_wdata = w_cam_data;
    end
  end

  assign sob_rd     = ctrl.ctrl_wr_valid && w_busy && (r_port == PORT_SOB);
  assign busy       = w_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Randomised bench for sdram_burst_arbiter against a transaction-level model of grants and addresses.
`timescale 1ns/1ps
module tb_sdram_burst_arbiter;

  localparam int BL  = 512;
  localparam int FB  = 600;
  localparam int RLM = 250;
  localparam int P_SOB = 0;
  localparam int P_CAM = 1;
  localparam int P_VGA = 2;
`ifdef ORIG_PORT_EN
  localparam bit ORIG_EN = 1'b1;
`else
  localparam bit ORIG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  sob_count, cam_count, vga_count;
  logic [15:0] sob_data, cam_data;
  logic        sob_rd, vga_sel_orig, busy, frame_done;
`ifdef ORIG_PORT_EN
  logic        cam_rd;
`endif

  sdram_burst_arbiter_if ctrl_bus();

  sdram_burst_arbiter #(
    .BURST_LEN    (BL),
    .FRAME_BURSTS (FB),
    .RD_LOW_MARK  (RLM)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sob_count    (sob_count),
    .sob_data     (sob_data),
    .sob_rd       (sob_rd),
`ifdef ORIG_PORT_EN
    .cam_count    (cam_count),
    .cam_data     (cam_data),
    .cam_rd       (cam_rd),
`endif
    .vga_count    (vga_count),
    .vga_sel_orig (vga_sel_orig),
    .ctrl         (ctrl_bus),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: bursts granted per port, latched display select, round-robin memory
  int n_sob, n_cam, n_rd;
  bit sel_lat;
  int last_w;
  int fd_exp  = 0;
  int fd_seen = 0;

  always @(negedge clk) if (rst_n && frame_done) fd_seen++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    n_sob = 0; n_cam = 0; n_rd = 0; sel_lat = 1'b0; last_w = P_CAM;
  endtask

  function automatic int pick_port();
    bit s, c;
    if (int'(vga_count) < RLM) return P_VGA;
    s = int'(sob_count) >= BL;
    c = ORIG_EN && (int'(cam_count) >= BL);
    if (s && c) return (last_w == P_CAM) ? P_SOB : P_CAM;
    if (s) return P_SOB;
    if (c) return P_CAM;
    return -1;
  endfunction

  function automatic int exp_addr(input int p);
    if (p == P_SOB) return n_sob % FB;
    if (p == P_CAM) return FB + (n_cam % FB);
    return (n_rd % FB) + (sel_lat ? FB : 0);
  endfunction

  task automatic model_commit(input int p, output bit fd_next);
    fd_next = 1'b0;
    if (p == P_SOB) begin
      n_sob++; last_w = P_SOB;
      if (n_sob % FB == 0) begin fd_next = 1'b1; fd_exp++; end
    end else if (p == P_CAM) begin
      n_cam++; last_w = P_CAM;
    end else begin
      n_rd++;
      if (n_rd % FB == 0) sel_lat = ORIG_EN ? vga_sel_orig : 1'b0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_busy"},  busy, 0);
    check_val({tag, "_rw_en"}, ctrl_bus.ctrl_rw_en, 0);
    check_val({tag, "_rw"},    ctrl_bus.ctrl_rw, 0);
    check_val({tag, "_addr"},  ctrl_bus.ctrl_addr, 0);
    check_val({tag, "_wdata"}, ctrl_bus.ctrl_wdata, 0);
    check_val({tag, "_sobrd"}, sob_rd, 0);
    check_val({tag, "_fdone"}, frame_done, 0);
`ifdef ORIG_PORT_EN
    check_val({tag, "_camrd"}, cam_rd, 0);
`endif
  endtask

  // One request set up, granted, checked, and serviced by an emulated controller
  task automatic burst(input int sob, input int cam, input int vga, input bit sel, input bit hold_ready);
    int  p, k;
    bit  seen, fd_next;
    sob_count    = 10'(sob);
    cam_count    = 10'(cam);
    vga_count    = 10'(vga);
    vga_sel_orig = sel;
    ctrl_bus.ctrl_ready = 1'b1;
    p    = pick_port();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (ctrl_bus.ctrl_rw_en) seen = 1'b1;
    end
    if (!seen) begin
      check_val("grant_timeout", 0, 1);
      ctrl_bus.ctrl_ready = 1'b0;
      return;
    end
    check_val("grant_rw",   ctrl_bus.ctrl_rw, (p == P_VGA));
    check_val("grant_addr", ctrl_bus.ctrl_addr, exp_addr(p));
    check_val("grant_busy", busy, 1);
    model_commit(p, fd_next);
    ctrl_bus.ctrl_ready = hold_ready;
    @(posedge clk); #1;
    check_val("rw_en_pulse", ctrl_bus.ctrl_rw_en, 0);
    check_val("frame_done",  frame_done, fd_next);
    if (hold_ready) begin
      sob_count = '0; cam_count = '0; vga_count = 10'd900;
      repeat (3) @(posedge clk);
      #1 check_val("ready_stuck_busy", busy, 1);
      @(posedge clk); #1;
      check_val("ready_stuck_idle", busy, 0);
    end else begin
      k = $urandom_range(2, 5);
      repeat (k) begin
        ctrl_bus.ctrl_wr_valid = 1'($urandom);
        sob_data = 16'($urandom);
        cam_data = 16'($urandom);
        #1;
        check_val("sob_rd", sob_rd, ctrl_bus.ctrl_wr_valid && (p == P_SOB));
`ifdef ORIG_PORT_EN
        check_val("cam_rd", cam_rd, ctrl_bus.ctrl_wr_valid && (p == P_CAM));
`endif
        check_val("wdata", ctrl_bus.ctrl_wdata,
                  (p == P_SOB) ? sob_data : ((p == P_CAM) ? cam_data : 16'd0));
        check_val("burst_busy", busy, 1);
        @(posedge clk); #1;
      end
      ctrl_bus.ctrl_wr_valid = 1'b0;
    end
  endtask

  task automatic idle_check();
    ctrl_bus.ctrl_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check_val("no_req_rw_en", ctrl_bus.ctrl_rw_en, 0);
    end
    check_val("no_req_busy", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_before;
    rst_n = 1'b0;
    sob_count = '0; cam_count = '0; vga_count = 10'd900; vga_sel_orig = 1'b0;
    sob_data = 16'h1234; cam_data = 16'h5678;
    ctrl_bus.ctrl_ready = 1'b0;
    ctrl_bus.ctrl_wr_valid = 1'b1;
    model_reset();
    #12 check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    ctrl_bus.ctrl_wr_valid = 1'b0;
    rst_n = 1'b1;

    idle_check();
    // Sobel only, then read preempting a pending Sobel write
    burst(600, 0, 900, 0, 0);
    burst(600, 0, 900, 0, 0);
    burst(600, 0, 100, 0, 0);
    burst(600, 0, 900, 0, 0);
    // Both writers pending: alternation
    repeat (4) burst(600, 600, 900, 0, 0);
    // Controller that never drops ready
    burst(600, 0, 900, 0, 1);

    // A full frame of Sobel bursts: exactly one frame_done
    fd_before = fd_seen;
    repeat (FB) burst(600, 0, 900, 0, 0);
    @(negedge clk);
    check_val("frame_done_once", fd_seen - fd_before, 1);

    // Select flips mid-frame; takes effect only after the read pointer wraps
    for (int i = 0; i < FB + 2; i++) burst(0, 0, 100, (i >= FB / 2), 0);

    // Reset while the controller is mid-burst
    burst(600, 0, 900, 0, 0);
    #2;
    ctrl_bus.ctrl_wr_valid = 1'b1;
    rst_n = 1'b0;
    #1 check_outputs_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1 check_outputs_zero("held_reset");
    @(negedge clk);
    ctrl_bus.ctrl_wr_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    burst(600, 600, 900, 0, 0);
    burst(0, 0, 100, 0, 0);

    for (int i = 0; i < 150; i++) begin
      sob_count    = 10'($urandom_range(0, 1023));
      cam_count    = 10'($urandom_range(0, 1023));
      vga_count    = 10'($urandom_range(0, 1023));
      vga_sel_orig = 1'($urandom);
      if (pick_port() < 0) idle_check();
      else burst(int'(sob_count), int'(cam_count), int'(vga_count), vga_sel_orig,
                 ($urandom_range(0, 9) == 0));
    end

    @(negedge clk);
    check_val("frame_done_total", fd_seen, fd_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_burst_arbiter.md
SDRAM_BURST_ARBITER -- requirements
Module: sdram_burst_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 512, words per full-page burst.
REQ-002 SHALL have parameter FRAME_BURSTS, default 600, bursts per frame region.
REQ-003 SHALL have parameter RD_LOW_MARK, default 250, VGA FIFO refill threshold.
REQ-004 SHALL have ports clk in 1 (143 MHz SDRAM clock) and rst_n in 1 (reset, asynchronous, active-low).
REQ-005 SHALL have ports sob_count in 10 (Sobel FIFO fill), sob_data in 16, and sob_rd out 1 (Sobel FIFO pop).
REQ-006 SHALL have ports cam_count in 10, cam_data in 16, and cam_rd out 1 (camera FIFO pop; present only with ORIG_PORT_EN).
REQ-007 SHALL have ports vga_count in 10 (VGA FIFO fill, clk domain) and vga_sel_orig in 1 (display camera region when 1).
REQ-008 SHALL have controller-side ports ctrl_ready in 1, ctrl_wr_valid in 1 (f2s_data_valid), ctrl_rw out 1 (1=read), ctrl_rw_en out 1, ctrl_addr out 15, and ctrl_wdata out 16.
REQ-009 SHALL have status ports busy out 1 and frame_done out 1 (one-cycle pulse per completed Sobel frame).

Function
REQ-010 SHALL implement the states IDLE, GRANT, WAIT_BUSY and WAIT_DONE.
REQ-011 In IDLE with ctrl_ready=1, SHALL select a requester: read if vga_count<RD_LOW_MARK, otherwise a write port whose count>=BURST_LEN, otherwise none.
REQ-012 SHALL give a pending read strict priority over writes.
REQ-013 SHALL arbitrate between eligible write ports round-robin, with the last-granted port losing ties.
REQ-014 In GRANT, SHALL drive ctrl_rw_en=1 for exactly one cycle with ctrl_rw and ctrl_addr valid, then enter WAIT_BUSY.
REQ-015 SHALL leave WAIT_BUSY on ctrl_ready=0, entering WAIT_DONE, then return to IDLE on ctrl_ready=1.
REQ-016 SHALL return to IDLE from WAIT_BUSY if ctrl_ready stays 1 for 4 cycles.
REQ-017 SHALL map Sobel burst addresses to 0..FRAME_BURSTS-1 and camera burst addresses to FRAME_BURSTS..2*FRAME_BURSTS-1.
REQ-018 SHALL keep per-port write pointers that wrap to the region base after the last burst.
REQ-019 SHALL pulse frame_done when the Sobel write pointer wraps.
REQ-020 SHALL keep a read pointer in 0..FRAME_BURSTS-1 and add the camera region base when the latched vga_sel_orig=1.
REQ-021 SHALL sample vga_sel_orig only when the read pointer wraps to 0 (and at reset).
REQ-022 SHALL drive sob_rd or cam_rd equal to ctrl_wr_valid, gated by the granted port and combinational from ctrl_wr_valid.
REQ-023 SHALL mux ctrl_wdata combinationally from the granted port's data.
REQ-024 SHALL advance a pointer only in the GRANT cycle of its own burst.
REQ-025 SHALL assert busy in every state except IDLE.
REQ-026 SHALL default every output to 0 outside its asserting condition.

Reset
REQ-027 SHALL reset asynchronously to state IDLE, all pointers 0, round-robin last=camera (Sobel first), and latched select 0.
REQ-028 SHALL drive all outputs to 0 during reset.
REQ-029 SHALL, on reset mid-burst, abandon the burst without recovery; the controller is reset by the same rst_n.

Configuration
REQ-030 With ORIG_PORT_EN defined, SHALL include the camera write port, camera region and round-robin.
REQ-031 Without ORIG_PORT_EN, SHALL omit cam_* ports, treat vga_sel_orig as 0, and arbitrate only between Sobel write and VGA read.

Structure
REQ-032 SHALL place the state encoding, the port-ID enum {PORT_SOB, PORT_CAM, PORT_VGA} and the default parameter constants in shared package sdram_pkg.
REQ-033 SHALL use one sub-module, burst_ptr, for a wrapping burst pointer with base offset, used per port.

Verification
REQ-034 Bench SHALL cover: sob_count=600, vga_count=900, ctrl_ready=1 -> one ctrl_rw_en pulse with rw=0, addr=0; next Sobel burst addr=1.
REQ-035 Bench SHALL cover: sob_count=600 and vga_count=100 in the same cycle -> read granted first (rw=1, addr=0); Sobel write follows.
REQ-036 Bench SHALL cover: sob_count=cam_count=600 held -> grants alternate Sobel(0), camera(600), Sobel(1), camera(601).
REQ-037 Bench SHALL cover: 600 Sobel bursts -> pointer wraps to 0 and frame_done pulses once.
REQ-038 Bench SHALL cover: vga_sel_orig toggled mid-frame -> read addresses unchanged until wrap, then read from 600.
REQ-039 Bench SHALL cover: rst_n low during WAIT_DONE -> all outputs 0 immediately; after release, first grant at addr 0.
